// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the data-memory arbiter.
// A request or response transfers on a cycle where its valid and ready are both high; valid never waits on ready.
interface dmem_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_addr;
    logic [32*NREQ-1:0]   req_wdata;
    logic [4*NREQ-1:0]    req_wmask;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [31:0]          rsp_data;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_wmask;
    logic [31:0]          mem_data;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_wmask, rsp_ready, mem_data,
        output req_ready, rsp_valid, rsp_data, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_wmask, rsp_ready, mem_data,
        input  req_ready, rsp_valid, rsp_data, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one registered-read data-memory port among NREQ requesters,
// with a hold register that keeps a response stable while its owner back-pressures.
module dmem_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    bus,
    output logic [1:0]       dbg_state_o,
    output logic [PTR_W-1:0] dbg_owner_o,
    output logic [PTR_W-1:0] dbg_ptr_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [31:0]        hold_q, hold_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic               can_grant;
    logic               grant;
    logic [PTR_W-1:0]   gidx;
    logic [PTR_W-1:0]   cand;
    int                 idx;

    // First valid requester at or above ptr, wrapping; nothing is granted while a response is stuck.
    always_comb begin
        grant     = 1'b0;
        gidx      = '0;
        cand      = '0;
        idx       = 0;
        can_grant = (state_q == IDLE) || bus.rsp_ready[owner_q];
        if (!reset && can_grant) begin
            for (int k = 0; k < NREQ; k++) begin
                idx  = (int'(ptr_q) + k) % NREQ;
                cand = PTR_W'(idx);
                if (!grant && bus.req_valid[cand]) begin
                    grant = 1'b1;
                    gidx  = cand;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        hold_d        = hold_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        bus.mem_wmask = '0;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;

        if (grant) begin
            bus.req_ready[gidx] = 1'b1;
            bus.mem_addr        = bus.req_addr[int'(gidx)*32 +: 32];
            bus.mem_wdata       = bus.req_wdata[int'(gidx)*32 +: 32];
            bus.mem_wmask       = bus.req_wmask[int'(gidx)*4 +: 4];
            owner_d             = gidx;
            ptr_d               = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
            addr_d              = bus.req_addr[int'(gidx)*32 +: 32];
            wdata_d             = bus.req_wdata[int'(gidx)*32 +: 32];
        end

        case (state_q)
            IDLE: begin
                if (grant) state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid[owner_q] = 1'b1;
                bus.rsp_data           = bus.mem_data;
                if (bus.rsp_ready[owner_q]) begin
                    state_d = grant ? RESP : IDLE;
                end else begin
                    hold_d  = bus.mem_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                bus.rsp_valid[owner_q] = 1'b1;
                bus.rsp_data           = hold_q;
                if (bus.rsp_ready[owner_q]) state_d = grant ? RESP : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset silences the port combinationally so nothing leaks out before the first edge.
        if (reset) begin
            bus.rsp_valid = '0;
            bus.rsp_data  = '0;
            bus.mem_addr  = '0;
            bus.mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign dbg_state_o = state_q;
    assign dbg_owner_o = owner_q;
    assign dbg_ptr_o   = ptr_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a registered-read memory, a transaction-level reference model,
// directed scenarios followed by random traffic.
module tb_dmem_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.NREQ(N)) bus();
    logic [1:0] dbg_state;
    logic [1:0] dbg_owner;
    logic [1:0] dbg_ptr;

    dmem_arbiter #(.NREQ(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state),
        .dbg_owner_o (dbg_owner),
        .dbg_ptr_o   (dbg_ptr)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'h11223344;
        return 32'(i) * 32'h9E3779B1 + 32'h1234;
    endfunction

    // Memory port: registered read, byte-masked write, plus a backdoor for external rewrites.
    logic [31:0] mem [256];
    logic        init_en;
    logic        bd_en;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;
    always @(posedge clk) begin
        bus.mem_data <= mem[bus.mem_addr[9:2]];
        if (init_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_wmask[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            if (bd_en) mem[bd_idx] <= bd_data;
        end
    end

    // Reference model: what is outstanding, for whom, with which data.
    logic [31:0] ref_mem [256];
    bit          m_busy;
    int          m_owner, m_ptr, last_g;
    logic [31:0] m_data, m_addr, m_wdata;
    logic [N-1:0] obs_rr, obs_rv;
    logic [31:0]  obs_rd;
    logic [3:0]   obs_wm;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(int i, bit v, logic [31:0] a, logic [31:0] w, logic [3:0] m);
        bus.req_valid[i]         = v;
        bus.req_addr[32*i +: 32] = a;
        bus.req_wdata[32*i +: 32] = w;
        bus.req_wmask[4*i +: 4]  = m;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // One clock: compare all outputs mid-cycle, advance the model, then step past the edge.
    task automatic cycle();
        logic [N-1:0] e_rr, e_rv;
        logic [31:0]  e_rd, e_ad, e_wd, ga, gw;
        logic [3:0]   e_wm, gm;
        int g;
        bit gr;
        @(negedge clk);
        e_rr = '0; e_rv = '0; e_rd = '0; e_wm = '0; gr = 0; g = 0;
        ga = '0; gw = '0; gm = '0;
        if (reset) begin
            e_ad = '0; e_wd = '0;
        end else begin
            e_ad = m_addr; e_wd = m_wdata;
            if (m_busy) begin
                e_rv = N'(1) << m_owner;
                e_rd = m_data;
            end
            if (!m_busy || bus.rsp_ready[m_owner]) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (!gr && bus.req_valid[i]) begin gr = 1; g = i; end
                end
            end
            if (gr) begin
                ga = bus.req_addr[32*g +: 32];
                gw = bus.req_wdata[32*g +: 32];
                gm = bus.req_wmask[4*g +: 4];
                e_rr = N'(1) << g;
                e_wm = gm; e_ad = ga; e_wd = gw;
            end
            chk("ptr", 32'(dbg_ptr), 32'(m_ptr));
        end
        chk("req_ready", 32'(bus.req_ready), 32'(e_rr));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
        chk("rsp_data", bus.rsp_data, e_rd);
        chk("mem_wmask", 32'(bus.mem_wmask), 32'(e_wm));
        chk("mem_addr", bus.mem_addr, e_ad);
        chk("mem_wdata", bus.mem_wdata, e_wd);
        obs_rr = bus.req_ready; obs_rv = bus.rsp_valid; obs_rd = bus.rsp_data; obs_wm = bus.mem_wmask;

        if (reset) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_addr = '0; m_wdata = '0; last_g = -1;
        end else begin
            if (m_busy && bus.rsp_ready[m_owner]) m_busy = 0;
            last_g = gr ? g : -1;
            if (gr) begin
                m_data = ref_mem[ga[9:2]];
                for (int b = 0; b < 4; b++)
                    if (gm[b]) ref_mem[ga[9:2]][8*b +: 8] = gw[8*b +: 8];
                m_busy = 1; m_owner = g; m_ptr = (g + 1) % N; m_addr = ga; m_wdata = gw;
            end
        end
        if (bd_en) ref_mem[bd_idx] = bd_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        m_busy = 0; m_owner = 0; m_ptr = 0; m_addr = '0; m_wdata = '0; m_data = '0; last_g = -1;
        reset = 1'b1; init_en = 1'b1; bd_en = 1'b0; bd_idx = '0; bd_data = '0;
        bus.rsp_ready = '0;
        clear_reqs();

        // Reset with a write pending: nothing granted, nothing written.
        set_req(0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'hF);
        cycle();
        init_en = 1'b0;
        cycle();
        cycle();
        chk("rst_req_ready", 32'(obs_rr), 32'h0);
        chk("rst_wmask", 32'(obs_wm), 32'h0);
        reset = 1'b0;
        clear_reqs();
        bus.rsp_ready = 3'b111;
        cycle();
        chk("rst_no_write", mem[5], init_word(5));
        chk("rst_state", 32'(dbg_state), 32'h0);

        // Single read.
        set_req(0, 1'b1, 32'h10, 32'h0, 4'h0);
        cycle();
        chk("single_grant", 32'(last_g), 32'd0);
        chk("single_rr", 32'(obs_rr), 32'h1);
        clear_reqs();
        cycle();
        chk("single_rv", 32'(obs_rv), 32'h1);
        chk("single_data", obs_rd, 32'hDEADBEEF);

        // Byte write then read-back.
        set_req(1, 1'b1, 32'h20, 32'h000000AA, 4'b0001);
        cycle();
        chk("bw_grant", 32'(last_g), 32'd1);
        set_req(1, 1'b1, 32'h20, 32'h0, 4'h0);
        cycle();
        chk("bw_regrant", 32'(last_g), 32'd1);
        clear_reqs();
        cycle();
        chk("bw_data", obs_rd, 32'h112233AA);

        // Contention from ptr 0.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h40 + 32'(4*i), 32'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("cont_grant", 32'(last_g), 32'(k % 3));
            if (k > 0) chk("cont_rv", 32'(obs_rv), 32'(1 << ((k - 1) % 3)));
        end
        clear_reqs();
        cycle();
        chk("cont_last_rv", 32'(obs_rv), 32'h4);

        // Back-pressure with the word rewritten underneath the held response.
        set_req(0, 1'b1, 32'h10, 32'h0, 4'h0);
        cycle();
        chk("bp_grant", 32'(last_g), 32'd0);
        clear_reqs();
        set_req(1, 1'b1, 32'h24, 32'h0, 4'h0);
        set_req(2, 1'b1, 32'h28, 32'h0, 4'h0);
        bus.rsp_ready = 3'b110;
        bd_en = 1'b1; bd_idx = 8'd4; bd_data = 32'h55555555;
        for (int k = 0; k < 3; k++) begin
            cycle();
            bd_en = 1'b0;
            chk("bp_rr", 32'(obs_rr), 32'h0);
            chk("bp_rv", 32'(obs_rv), 32'h1);
            chk("bp_data", obs_rd, 32'hDEADBEEF);
        end
        bus.rsp_ready = 3'b111;
        cycle();
        chk("bp_release_grant", 32'(last_g), 32'd1);
        clear_reqs();
        cycle();

        // Reset while holding, with req2's write pending.
        set_req(0, 1'b1, 32'h10, 32'h0, 4'h0);
        bus.rsp_ready = 3'b110;
        cycle();
        clear_reqs();
        cycle();
        chk("hold_state", 32'(dbg_state), 32'h2);
        set_req(2, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        bus.rsp_ready = 3'b111;
        set_req(1, 1'b1, 32'h34, 32'h0, 4'h0);
        cycle();
        chk("rh_rv", 32'(obs_rv), 32'h0);
        chk("rh_grant", 32'(last_g), 32'd1);
        chk("rh_no_write", mem[12], init_word(12));
        clear_reqs();
        cycle();

        // Idle.
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("idle_wmask", 32'(obs_wm), 32'h0);
            chk("idle_rv", 32'(obs_rv), 32'h0);
        end

        // Random traffic.
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                        $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0);
            for (int i = 0; i < N; i++) bus.rsp_ready[i] = ($urandom_range(0, 9) < 7);
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;
        clear_reqs();
        bus.rsp_ready = 3'b111;
        cycle();
        cycle();

        for (int i = 0; i < 256; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares one port of the dual-port data memory (registered read, byte-masked write, one-cycle read latency) among NREQ requesters such as a core LSU, a DMA/loader and a debug port. It grants at most one request per cycle, returns read data on a per-requester response handshake, and buffers the memory output when a requester back-pressures. It sits between the requesters and a single `data_mem` port (`b_*` or `a_*`).

## Interface
- NREQ, 3: number of requesters, 2..8; requester i uses slice i of every flattened bus.
- PTR_W, $clog2(NREQ): width of the round-robin pointer and owner index.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_addr  in  32*NREQ  byte address; requester i at [32*i+31:32*i].
- req_wdata  in  32*NREQ  write data; requester i at [32*i+31:32*i].
- req_wmask  in  4*NREQ  byte write mask; 0 means read.
- req_ready  out  NREQ  one-hot grant; request accepted when valid&ready.
- rsp_valid  out  NREQ  one-hot response valid for the owning requester.
- rsp_ready  in  NREQ  requester accepts its response.
- rsp_data  out  32  response data, shared by all requesters.
- mem_addr  out  32  to memory port address.
- mem_wdata  out  32  to memory port write data.
- mem_wmask  out  4  to memory port write mask.
- mem_data  in  32  memory port registered read data, valid one cycle after address.

## Operation
- States: IDLE (nothing outstanding), RESP (memory output for owner arrives this cycle), HOLD (owner's data captured in hold register).
- `can_grant` = IDLE, or (RESP/HOLD and rsp_ready[owner]). When can_grant is low, req_ready is all zeros.
- Grant selection: the first i with req_valid[i], searching from ptr upward and wrapping modulo NREQ. On grant g: req_ready[g]=1 (combinational, same cycle), mem_addr/wdata/wmask = requester g's slice, owner<=g, ptr<=(g+1) mod NREQ.
- No grant in a cycle: mem_wmask=0; mem_addr and mem_wdata hold their last granted values (registered mirror). Spurious writes are not permitted.
- IDLE: grant -> RESP; no grant -> IDLE.
- RESP: rsp_valid[owner]=1, rsp_data=mem_data. If rsp_ready[owner]: response done; a new grant in the same cycle -> RESP, else -> IDLE. If not rsp_ready: hold<=mem_data -> HOLD.
- HOLD: rsp_valid[owner]=1, rsp_data=hold (stable). On rsp_ready[owner]: new grant -> RESP, else -> IDLE.
- Writes also produce one response (acknowledge); its rsp_data is the word read in the write cycle (pre-write contents) and is don't-care for the requester.
- rsp_valid is never asserted for a non-owner; ptr changes only on a grant.
- Address bits [1:0] pass through unchanged; word alignment is the requester's responsibility.

## Timing
- Reset (while reset high, and after): state=IDLE, owner=0, ptr=0, hold=0, mem_addr=0, mem_wdata=0; req_ready=0, rsp_valid=0, mem_wmask=0, rsp_data=0. A request presented during reset is not granted and no write reaches memory.
- Reset mid-operation (RESP/HOLD) drops the outstanding response; no rsp_valid in the following cycle.
- Latency: grant at cycle T -> rsp_valid at T+1 with data from the memory edge at end of T.
- Throughput: one transaction per cycle while owners accept responses same cycle.
- Back-pressure: HOLD may last indefinitely; rsp_data stays constant, no grants occur.
- Simultaneous rsp_ready[owner] and new request from the same requester: legal, granted if first in RR order.
- Single valid requester: granted every cycle regardless of ptr.
- Writes take effect at the memory edge ending the grant cycle; a read granted at T+1 to the same address returns the new data.

## Test plan
- Single read: DATARAM word 0x10 = 0xDEADBEEF; req0 reads 0x10 at T with rsp_ready=1 -> req_ready=3'b001 at T, rsp_valid=3'b001 and rsp_data=0xDEADBEEF at T+1, then IDLE.
- Byte write: word 0x20 = 0x11223344; req1 writes wdata 0x000000AA, wmask 4'b0001, then reads 0x20 -> rsp_data 0x112233AA.
- Contention: all three requesters hold valid reads, rsp_ready all 1 -> grants 0,1,2,0,1,2 on consecutive cycles, one response per cycle to the matching requester.
- Back-pressure: req0 read 0x10 (0xDEADBEEF), rsp_ready[0]=0 for 3 cycles while req1/req2 valid and word 0x10 is rewritten externally -> req_ready=0, rsp_data stays 0xDEADBEEF. On release, req1 is granted in the same cycle.
- Reset in HOLD: reset high one cycle with req2 write pending -> all outputs 0 next cycle, ptr=0, req2's word unchanged, next grant goes to lowest valid index.
- Idle: no requests for 10 cycles -> mem_wmask=0 every cycle, rsp_valid=0, memory contents unchanged.
